// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The registered in_ready breaks the combinational ready path; stall_cnt saturates.
module ex_mem_skid_reg #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int FUNC_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_addsum,
  input  logic [XLEN-1:0]    in_alures,
  input  logic [XLEN-1:0]    in_rd2,
  input  logic [XLEN-1:0]    in_wdata,
  input  logic               in_zero,
  input  logic               in_gt,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [FUNC_W-1:0]  in_func,
  input  logic               in_regwrite,
  input  logic               in_memtoreg,
  input  logic               in_branch,
  input  logic               in_memread,
  input  logic               in_memwrite,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_addsum,
  output logic [XLEN-1:0]    out_alures,
  output logic [XLEN-1:0]    out_rd2,
  output logic [XLEN-1:0]    out_wdata,
  output logic               out_zero,
  output logic               out_gt,
  output logic [RADDR_W-1:0] out_rd,
  output logic [FUNC_W-1:0]  out_func,
  output logic               out_regwrite,
  output logic               out_memtoreg,
  output logic               out_branch,
  output logic               out_memread,
  output logic               out_memwrite,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int PW = 4 * XLEN + 2 + RADDR_W + FUNC_W + 5;

  // Bit 0 is the MAIN valid bit, bit 1 the SKID valid bit.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] main_q, skid_q, in_pl;
  logic [4:0]    main_ctrl;
  logic          push, pop;
  logic          load_main, load_skid, skid_to_main;

  assign in_pl = {in_addsum, in_alures, in_rd2, in_wdata, in_zero, in_gt, in_rd, in_func,
                  in_regwrite, in_memtoreg, in_branch, in_memread, in_memwrite};

  assign {out_addsum, out_alures, out_rd2, out_wdata, out_zero, out_gt, out_rd, out_func,
          main_ctrl} = main_q;

  assign out_valid    = state[0];
  assign out_regwrite = main_ctrl[4] & out_valid;
  assign out_memtoreg = main_ctrl[3] & out_valid;
  assign out_branch   = main_ctrl[2] & out_valid;
  assign out_memread  = main_ctrl[1] & out_valid;
  assign out_memwrite = main_ctrl[0] & out_valid;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_n   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_n   = TWO;
        end else if (pop) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          skid_to_main = 1'b1;
          state_n      = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != TWO);
      if (load_main) begin
        main_q <= in_pl;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pl;
      end
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: handshakes push expected entries into a queue,
// pops compare them against the memory-stage outputs, plus timing/reset/flush checks.
module tb_ex_mem_skid_reg;

  localparam int PW = 272;

  typedef struct packed {
    logic [63:0] addsum;
    logic [63:0] alures;
    logic [63:0] rd2;
    logic [63:0] wdata;
    logic        zero;
    logic        gt;
    logic [4:0]  rd;
    logic [3:0]  func;
    logic        regwrite;
    logic        memtoreg;
    logic        branch;
    logic        memread;
    logic        memwrite;
  } payload_t;

  logic     clk = 1'b0;
  logic     rst_n, flush, in_valid, out_ready;
  payload_t in_pl;

  logic        in_ready, out_valid;
  logic [63:0] out_addsum, out_alures, out_rd2, out_wdata;
  logic        out_zero, out_gt, out_regwrite, out_memtoreg, out_branch, out_memread, out_memwrite;
  logic [4:0]  out_rd;
  logic [3:0]  out_func;
  logic [15:0] stall_cnt;
  payload_t    out_pl;

  logic        in_ready4, out_valid4;
  logic [63:0] out_addsum4, out_alures4, out_rd24, out_wdata4;
  logic        out_zero4, out_gt4, out_regwrite4, out_memtoreg4, out_branch4, out_memread4, out_memwrite4;
  logic [4:0]  out_rd4;
  logic [3:0]  out_func4;
  logic [3:0]  stall_cnt4;
  payload_t    out_pl4;

  payload_t sb[$];
  int       compared = 0;
  int       mismatched = 0;

  always #5 clk = ~clk;

  assign out_pl  = {out_addsum, out_alures, out_rd2, out_wdata, out_zero, out_gt, out_rd, out_func,
                    out_regwrite, out_memtoreg, out_branch, out_memread, out_memwrite};
  assign out_pl4 = {out_addsum4, out_alures4, out_rd24, out_wdata4, out_zero4, out_gt4, out_rd4,
                    out_func4, out_regwrite4, out_memtoreg4, out_branch4, out_memread4, out_memwrite4};

  ex_mem_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_addsum(in_pl.addsum), .in_alures(in_pl.alures), .in_rd2(in_pl.rd2), .in_wdata(in_pl.wdata),
    .in_zero(in_pl.zero), .in_gt(in_pl.gt), .in_rd(in_pl.rd), .in_func(in_pl.func),
    .in_regwrite(in_pl.regwrite), .in_memtoreg(in_pl.memtoreg), .in_branch(in_pl.branch),
    .in_memread(in_pl.memread), .in_memwrite(in_pl.memwrite),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addsum(out_addsum), .out_alures(out_alures), .out_rd2(out_rd2), .out_wdata(out_wdata),
    .out_zero(out_zero), .out_gt(out_gt), .out_rd(out_rd), .out_func(out_func),
    .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_branch(out_branch),
    .out_memread(out_memread), .out_memwrite(out_memwrite), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation checks.
  ex_mem_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_addsum(in_pl.addsum), .in_alures(in_pl.alures), .in_rd2(in_pl.rd2), .in_wdata(in_pl.wdata),
    .in_zero(in_pl.zero), .in_gt(in_pl.gt), .in_rd(in_pl.rd), .in_func(in_pl.func),
    .in_regwrite(in_pl.regwrite), .in_memtoreg(in_pl.memtoreg), .in_branch(in_pl.branch),
    .in_memread(in_pl.memread), .in_memwrite(in_pl.memwrite),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_addsum(out_addsum4), .out_alures(out_alures4), .out_rd2(out_rd24), .out_wdata(out_wdata4),
    .out_zero(out_zero4), .out_gt(out_gt4), .out_rd(out_rd4), .out_func(out_func4),
    .out_regwrite(out_regwrite4), .out_memtoreg(out_memtoreg4), .out_branch(out_branch4),
    .out_memread(out_memread4), .out_memwrite(out_memwrite4), .stall_cnt(stall_cnt4)
  );

  function automatic payload_t mk(input logic [31:0] k);
    payload_t p;
    p.addsum   = {32'hA5A5_0000, k};
    p.alures   = {32'h0, k};
    p.rd2      = ~{32'h0, k};
    p.wdata    = {k, 32'hDEAD_BEEF};
    p.zero     = k[0];
    p.gt       = k[1];
    p.rd       = k[4:0];
    p.func     = k[3:0];
    p.regwrite = k[0];
    p.memtoreg = k[1];
    p.branch   = k[2];
    p.memread  = k[3];
    p.memwrite = ~k[0];
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drives one cycle, updates the scoreboard, returns at the next negedge.
  task automatic applyStimulus(input logic v, input payload_t p, input logic ordy,
                               input logic fl, input logic rn);
    logic push, pop;
    in_valid  = v;
    in_pl     = p;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    #1;
    push = v && (in_ready === 1'b1) && rn && !fl;
    pop  = (out_valid === 1'b1) && ordy && rn && !fl;
    if (pop) begin
      if (sb.size() == 0) checkOutput("sb_underflow", PW'(sb.size()), PW'(1));
      else checkOutput("pop_entry", out_pl, sb.pop_front());
    end
    if (!rn || fl) sb.delete();
    else if (push) sb.push_back(p);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int sent, got_cnt, budget;
    logic ordy;
    payload_t f;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pl = '0;
    @(negedge clk);

    // Reset held for two cycles
    applyStimulus(0, mk(99), 1, 0, 0);
    checkOutput("in_ready_in_reset", PW'(in_ready), PW'(1));
    applyStimulus(1, mk(98), 1, 0, 0);
    checkOutput("reset_out_valid", PW'(out_valid), PW'(0));
    checkOutput("reset_out_payload", out_pl, PW'(0));
    checkOutput("reset_stall_cnt", PW'(stall_cnt), PW'(0));
    checkOutput("reset_in_ready", PW'(in_ready), PW'(1));
    checkOutput("reset_dut4_outputs", {out_pl4, in_ready4, out_valid4, stall_cnt4}, PW'(6'b100000));

    // Stream 1..8 at full throughput, one-cycle latency
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, mk(k), 1, 0, 1);
      checkOutput("stream_valid", PW'(out_valid), PW'(1));
      checkOutput("stream_alures", PW'(out_alures), PW'(k));
    end
    applyStimulus(0, mk(0), 1, 0, 1);
    checkOutput("stream_drained", PW'(out_valid), PW'(0));
    checkOutput("stream_stall_cnt", PW'(stall_cnt), PW'(0));
    checkOutput("stream_sb_empty", PW'(sb.size()), PW'(0));

    // Back-pressure: one entry in MAIN, then five stall cycles with in_valid held high
    applyStimulus(1, mk(11), 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_in_ready_%0d", i), PW'(in_ready), PW'(i == 0 ? 1 : 0));
      applyStimulus(1, mk(12 + i), 0, 0, 1);
    end
    checkOutput("bp_held_entries", PW'(sb.size()), PW'(2));
    checkOutput("bp_stall_cnt", PW'(stall_cnt), PW'(5));
    applyStimulus(0, mk(0), 1, 0, 1);
    checkOutput("bp_recover_in_ready", PW'(in_ready), PW'(1));
    applyStimulus(0, mk(0), 1, 0, 1);
    checkOutput("bp_drained_valid", PW'(out_valid), PW'(0));
    checkOutput("bp_drained_sb", PW'(sb.size()), PW'(0));

    // Flush in TWO, with a push offered in the same cycle
    f = mk(21); f.memwrite = 1'b1; f.rd = 5'd7;
    applyStimulus(1, f, 0, 0, 1);
    f = mk(22); f.memwrite = 1'b1; f.rd = 5'd7;
    applyStimulus(1, f, 0, 0, 1);
    checkOutput("fl_two_in_ready", PW'(in_ready), PW'(0));
    checkOutput("fl_two_memwrite", PW'(out_memwrite), PW'(1));
    f = mk(23); f.memwrite = 1'b1; f.rd = 5'd7;
    applyStimulus(1, f, 1, 1, 1);
    checkOutput("fl_out_valid", PW'(out_valid), PW'(0));
    checkOutput("fl_out_memwrite", PW'(out_memwrite), PW'(0));
    checkOutput("fl_out_rd", PW'(out_rd), PW'(0));
    checkOutput("fl_in_ready", PW'(in_ready), PW'(1));
    checkOutput("fl_payload_zero", out_pl, PW'(0));
    checkOutput("fl_stall_cnt", PW'(stall_cnt), PW'(6));
    applyStimulus(0, mk(0), 1, 0, 1);
    checkOutput("fl_not_captured", PW'(out_valid), PW'(0));

    // Alternating out_ready, producer pushes 10 entries whenever accepted
    sent = 0; got_cnt = 0; budget = 0; ordy = 1'b1;
    while ((sent < 10 || sb.size() != 0) && budget < 80) begin
      if (out_valid === 1'b1 && ordy) got_cnt++;
      if (sent < 10) begin
        if (in_ready === 1'b1) begin
          applyStimulus(1, mk(40 + sent), ordy, 0, 1);
          sent++;
        end else begin
          applyStimulus(1, mk(40 + sent), ordy, 0, 1);
        end
      end else begin
        applyStimulus(0, mk(0), ordy, 0, 1);
      end
      ordy = ~ordy;
      budget++;
    end
    checkOutput("alt_within_budget", PW'(budget < 80), PW'(1));
    checkOutput("alt_delivered", PW'(got_cnt), PW'(10));

    // Counter saturation on the 4-bit instance
    applyStimulus(0, mk(0), 0, 0, 0);
    applyStimulus(1, mk(60), 0, 0, 1);
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(0, mk(0), 0, 0, 1);
      if (j == 14) checkOutput("sat_at_14", PW'(stall_cnt4), PW'(14));
      if (j == 15) checkOutput("sat_at_15", PW'(stall_cnt4), PW'(15));
    end
    checkOutput("sat_hold_15", PW'(stall_cnt4), PW'(15));
    checkOutput("sat_wide_20", PW'(stall_cnt), PW'(20));

    // Reset beats flush while in TWO with stall_cnt = 3
    applyStimulus(0, mk(0), 0, 0, 0);
    applyStimulus(1, mk(70), 0, 0, 1);
    applyStimulus(1, mk(71), 0, 0, 1);
    applyStimulus(0, mk(0), 0, 0, 1);
    applyStimulus(0, mk(0), 0, 0, 1);
    checkOutput("rbf_pre_cnt", PW'(stall_cnt), PW'(3));
    checkOutput("rbf_pre_in_ready", PW'(in_ready), PW'(0));
    applyStimulus(1, mk(72), 1, 1, 0);
    checkOutput("rbf_out_valid", PW'(out_valid), PW'(0));
    checkOutput("rbf_payload", out_pl, PW'(0));
    checkOutput("rbf_stall_cnt", PW'(stall_cnt), PW'(0));
    checkOutput("rbf_stall_cnt4", PW'(stall_cnt4), PW'(0));
    checkOutput("rbf_in_ready", PW'(in_ready), PW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised EX/MEM pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the execute stage and the memory stage. Unlike a plain always-load register, it can stall and flush. A full downstream stage back-pressures execute through a registered `in_ready`, so the ready path never forms a combinational loop. A saturating counter records downstream stall cycles for performance analysis.

## Interface
Parameters:
- `XLEN`, 64: width of `addsum`, `alures`, `rd2`, `wdata`
- `RADDR_W`, 5: destination register index width
- `FUNC_W`, 4: ALU/mem function code width
- `CNT_W`, 16: stall counter width

Ports:
- `clk` in 1: clock; all state updates on the rising edge
- `rst_n` in 1: reset; one clock, synchronous, active-low
- `flush` in 1: synchronous kill of all held entries
- `in_valid` in 1: execute stage presents an entry
- `in_ready` out 1: register can accept; registered output
- `in_addsum`, `in_alures`, `in_rd2`, `in_wdata` in XLEN each: payload
- `in_zero`, `in_gt` in 1 each: ALU flags
- `in_rd` in RADDR_W: destination register index
- `in_func` in FUNC_W: function code
- `in_regwrite`, `in_memtoreg`, `in_branch`, `in_memread`, `in_memwrite` in 1 each: control
- `out_valid` out 1: memory stage entry valid
- `out_ready` in 1: memory stage consumes the entry
- `out_*` out: same names and widths as every `in_*` payload and control field
- `stall_cnt` out CNT_W: saturating count of stall cycles

## Operation
- Storage is two entries: MAIN, which drives `out_*`, and SKID. Each entry has its own valid bit.
- State machine, encoded by the valid bits:
  - EMPTY: MAIN invalid, SKID invalid.
  - ONE: MAIN valid, SKID invalid.
  - TWO: MAIN valid, SKID valid.
- Define push = `in_valid & in_ready` and pop = `out_valid & out_ready`.
- Transitions from EMPTY:
  - push: input loads MAIN; go to ONE.
  - no push: stay in EMPTY.
- Transitions from ONE:
  - push and pop: input loads MAIN; stay in ONE.
  - push, no pop: input loads SKID; go to TWO.
  - pop, no push: go to EMPTY.
  - neither: stay in ONE.
- Transitions from TWO:
  - pop: SKID moves to MAIN; go to ONE.
  - no pop: stay in TWO.
  - push is impossible because `in_ready`=0.
- `in_ready` is registered. It is 1 exactly when the next state is not TWO.
- `out_valid` is 1 when MAIN is valid.
- Control gating:
  - `out_regwrite`, `out_memread`, `out_memwrite`, `out_branch` and `out_memtoreg` are ANDed with `out_valid`.
  - A bubble therefore never writes memory or the register file, and never redirects a branch.
- `flush`:
  - Clears both valid bits and zeroes every payload field of both entries.
  - Overrides a same-cycle push and pop.
  - Next state is EMPTY and `in_ready`=1.
- Reset (`rst_n`=0) has priority over `flush`. It applies the same clearing and also zeroes `stall_cnt`.
- `stall_cnt`:
  - Increments by 1 every cycle with `out_valid & ~out_ready` and no flush.
  - Saturates at 2^CNT_W−1 and never wraps.
  - Cleared only by reset.
- Payload is carried bit-exact; no arithmetic is performed on it.
- Entry order is preserved: SKID always holds the younger entry.

## Timing
- Reset values, one cycle after `rst_n` is sampled low:
  - `out_valid`=0, every `out_*`=0, `stall_cnt`=0.
  - `in_ready`=1; it remains 1 while `rst_n` is held low.
- Latency is one cycle. An entry pushed at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput is one entry per cycle while `out_ready`=1.
- `out_ready` falling:
  - MAIN holds its entry and one more push is absorbed into SKID.
  - `in_ready` drops one cycle after `out_ready` falls.
- Recovery: when `out_ready` rises in TWO, `in_ready` returns to 1 after the next edge.
- There are no combinational paths from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- Reset mid-operation discards both entries without emitting them. Flush does the same.

## Test plan
- Reset then stream: `rst_n`=0 for 2 cycles, then 8 entries with `in_alures`=1..8 and `out_ready`=1. Required: `out_alures`=1..8 on consecutive cycles at 1-cycle latency, `stall_cnt`=0.
- Back-pressure: `out_ready`=0 for 5 cycles while `in_valid`=1 continuously. Required:
  - Exactly 2 entries are accepted.
  - `in_ready`=0 from the 2nd stall cycle on.
  - `stall_cnt`=5.
  - After release, the entries emerge in order with no loss or duplication.
- Flush in TWO: fill both entries (`in_memwrite`=1, `in_rd`=7), then assert `flush` together with `in_valid`=1. Required:
  - The next cycle has `out_valid`=0, `out_memwrite`=0, `out_rd`=0, `in_ready`=1.
  - The entry flushed with the input is not captured.
- Simultaneous push and pop in ONE: 10 entries with `out_ready`=1 on alternating cycles. Required: order preserved, SKID used only on non-pop cycles.
- Counter saturation: `CNT_W`=4, `out_valid`=1, `out_ready`=0 for 20 cycles. Required: `stall_cnt` reaches 15 and holds at 15.
- Reset beats flush: assert `rst_n`=0 and `flush`=1 in the same cycle while in TWO with `stall_cnt`=3. Required: all outputs are at reset values, including `stall_cnt`=0.
